mem_sweep: RTL and testbench
============================

MEM_SWEEP -- requirements
Module: mem_sweep

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, RAM address width; DEPTH = 2**ADDR_W words, ADDR_W >= 2.
REQ-003 Port CLOCK_50_I  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port RESETN_I  input  1  asynchronous, active-low reset.
REQ-005 Port START_I  input  1  level; a sweep is requested on its 0->1 transition.
REQ-006 Port MODE_I  input  2  operation select, sampled at sweep start.
REQ-007 Port ADDR0_O / ADDR1_O  output  ADDR_W  RAM port 0 / port 1 address.
REQ-008 Port WDATA0_O / WDATA1_O  output  DATA_W  RAM port 0 / port 1 write data.
REQ-009 Port WE0_O / WE1_O  output  1  RAM port 0 / port 1 write enable.
REQ-010 Port RDATA0_I / RDATA1_I  input  DATA_W  RAM read data; valid in the cycle after the address is presented.
REQ-011 Port BUSY_O  output  1  high while a sweep is in progress.
REQ-012 Port DONE_O  output  1  one-cycle pulse on sweep completion.
REQ-013 Port OVF_CNT_O  output  ADDR_W  number of pairs whose result overflowed in the last sweep.

Function
REQ-014 SHALL detect the START_I rising edge with a registered previous value; a rising edge while BUSY_O=1 SHALL be ignored.
REQ-015 SHALL use the FSM states S_IDLE, S_READ, S_WRITE, S_DONE.
REQ-016 S_IDLE: on a START_I rising edge, latch MODE_I, clear pair index i and OVF_CNT_O, then go to S_READ.
REQ-017 S_READ: drive ADDR0_O=i and ADDR1_O=DEPTH-1-i with WE0_O=WE1_O=0, then go to S_WRITE.
REQ-018 S_WRITE: hold both addresses, assert WE0_O=WE1_O=1, and drive the write data from RDATA0_I (a) and RDATA1_I (b) per REQ-019.
REQ-018a S_WRITE: if i=DEPTH/2-1, go to S_DONE; otherwise increment i and go to S_READ.
REQ-019 Mode decode (a goes to port 0, b goes to port 1):
  - 0: port 0 gets a+b, port 1 gets a-b.
  - 1: port 0 gets max(a,b), port 1 gets min(a,b), unsigned.
  - 2: port 0 gets b, port 1 gets a (swap).
  - 3: port 0 gets a, port 1 gets b (rewrite in place).
REQ-020 Arithmetic is unsigned DATA_W.
REQ-020a In mode 0, a pair overflows if the carry out of a+b is set or if a<b.
REQ-020b Each overflowing pair SHALL increment OVF_CNT_O by exactly 1; other modes never overflow.
REQ-021 S_DONE: pulse DONE_O for one cycle, deassert BUSY_O in that same cycle, and return to S_IDLE.
REQ-022 BUSY_O SHALL be 1 in S_READ and S_WRITE only.
REQ-023 A sweep SHALL take exactly DEPTH cycles from the START edge cycle to DONE_O, i.e. 2 cycles per pair: 512 cycles at default parameters.
REQ-024 OVF_CNT_O SHALL hold its value until the next sweep starts.
REQ-025 If START_I is still high after DONE_O, no new sweep SHALL start until START_I falls and rises again.
REQ-026 WE0_O and WE1_O SHALL never be high outside S_WRITE.
REQ-026a The two port addresses SHALL never be equal during a write.

Reset
REQ-027 RESETN_I=0 SHALL immediately force S_IDLE and clear i.
REQ-027a RESETN_I=0 SHALL drive every output to 0: addresses, write data, WE, BUSY_O, DONE_O, OVF_CNT_O.
REQ-027b RESETN_I=0 SHALL clear the START edge register.
REQ-028 A reset mid-sweep SHALL abort the sweep with no further writes and no DONE_O pulse; RAM contents already written remain as written.

Configuration
REQ-029 When MEM_SWEEP_SAT_EN is defined, mode 0 SHALL saturate: a+b clamps to 2**DATA_W-1 and a-b clamps to 0.
REQ-030 When MEM_SWEEP_SAT_EN is undefined, mode 0 results SHALL wrap modulo 2**DATA_W.
REQ-030a OVF_CNT_O counting SHALL be identical with or without MEM_SWEEP_SAT_EN.

Structure
REQ-031 Package mem_sweep_pkg SHALL hold the FSM state enum and the mode enum (MODE_SUMDIFF, MODE_MAXMIN, MODE_SWAP, MODE_PASS).
REQ-032 Combinational sub-module mem_sweep_alu SHALL compute both write words and the overflow flag from a, b and the mode.

Verification
REQ-033 Bench SHALL use a behavioural dual-port RAM model with 1-cycle read latency.
REQ-034 Mode 0, RAM[k]=k, DEPTH=512, wrap build: RAM[0]=0+255 (8-bit wrap of 511) and RAM[511]=0-511 mod 256=1; DONE_O is seen 512 cycles after START; OVF_CNT_O equals the reference-model count.
REQ-035 Mode 0 with MEM_SWEEP_SAT_EN, a=200, b=100: port 0 writes 255, port 1 writes 100; OVF_CNT_O increments by 1.
REQ-036 Mode 1, RAM[0]=3 and RAM[511]=9: after the sweep, RAM[0]=9 and RAM[511]=3.
REQ-037 Mode 2 run twice: RAM is restored to its original contents; second START edge applied while BUSY_O=1 is ignored, so the sweep count stays 1.
REQ-038 RESETN_I=0 at pair 100 of a mode-3 sweep: all outputs 0 at once, no DONE_O; a new sweep after reset completes normally.

Source files
------------

// File: rtl/mem_sweep_pkg.sv
// Shared types for the mem_sweep RAM pair-sweep engine.
// FSM state and operation mode encodings.
package mem_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_SUMDIFF = 2'd0,
    MODE_MAXMIN  = 2'd1,
    MODE_SWAP    = 2'd2,
    MODE_PASS    = 2'd3
  } mode_e;

endpackage

// File: rtl/mem_sweep_if.sv
// Operand/result bundle between the sweep
// sequencer (master) and the pair ALU (slave).
interface mem_sweep_if #(
  parameter int DATA_W = 8
);
  import mem_sweep_pkg::*;

  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  mode_e             mode;
  logic [DATA_W-1:0] w0;
  logic [DATA_W-1:0] w1;
  logic              ovf;

  modport master (
    output a,
    output b,
    output mode,
    input  w0,
    input  w1,
    input  ovf
  );

  modport slave (
    input  a,
    input  b,
    input  mode,
    output w0,
    output w1,
    output ovf
  );

endinterface

// File: rtl/mem_sweep_alu.sv
// Pair ALU: both write words and overflow flag.
// MEM_SWEEP_SAT_EN selects saturating sum/diff.
module mem_sweep_alu
  import mem_sweep_pkg::*;
#(
  parameter int DATA_W = 8
) (
  mem_sweep_if.slave bus
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              lt;

  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = bus.a - bus.b;
  assign lt   = bus.a < bus.b;

  // Mode decode: a lands on port 0, b on port 1.
  always_comb begin
    bus.w0  = bus.a;
    bus.w1  = bus.b;
    bus.ovf = 1'b0;
    unique case (bus.mode)
      MODE_SUMDIFF: begin
        bus.ovf = sum[DATA_W] | lt;
`ifdef MEM_SWEEP_SAT_EN
        bus.w0 = sum[DATA_W] ? '1
               : sum[DATA_W-1:0];
        bus.w1 = lt ? '0 : diff;
`else
        bus.w0 = sum[DATA_W-1:0];
        bus.w1 = diff;
`endif
      end
      MODE_MAXMIN: begin
        bus.w0 = lt ? bus.b : bus.a;
        bus.w1 = lt ? bus.a : bus.b;
      end
      MODE_SWAP: begin
        bus.w0 = bus.b;
        bus.w1 = bus.a;
      end
      MODE_PASS: begin
        bus.w0 = bus.a;
        bus.w1 = bus.b;
      end
    endcase
  end

endmodule

// File: rtl/mem_sweep.sv
// Dual-port RAM sweep: pairs word i with DEPTH-1-i.
// Optional MEM_SWEEP_SAT_EN saturates mode 0.
module mem_sweep
  import mem_sweep_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK_50_I,
  input  logic              RESETN_I,
  input  logic              START_I,
  input  logic [1:0]        MODE_I,
  output logic [ADDR_W-1:0] ADDR0_O,
  output logic [ADDR_W-1:0] ADDR1_O,
  output logic [DATA_W-1:0] WDATA0_O,
  output logic [DATA_W-1:0] WDATA1_O,
  output logic              WE0_O,
  output logic              WE1_O,
  input  logic [DATA_W-1:0] RDATA0_I,
  input  logic [DATA_W-1:0] RDATA1_I,
  output logic              BUSY_O,
  output logic              DONE_O,
  output logic [ADDR_W-1:0] OVF_CNT_O
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH / 2 - 1);
  localparam logic [ADDR_W-1:0] TOP =
    ADDR_W'(DEPTH - 1);

  state_e            state;
  state_e            state_nx;
  mode_e             mode;
  logic              start_q;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] ovf_cnt;
  logic              go;

  mem_sweep_if #(.DATA_W(DATA_W)) alu_bus ();

  assign alu_bus.a    = RDATA0_I;
  assign alu_bus.b    = RDATA1_I;
  assign alu_bus.mode = mode;

  mem_sweep_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .bus(alu_bus.slave)
  );

  // Edges only count when idle; busy edges drop.
  assign go = START_I & ~start_q
            & (state == S_IDLE);

  // State register.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: two cycles per pair, then DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (go) state_nx = S_READ;
      S_READ:  state_nx = S_WRITE;
      S_WRITE: state_nx = (idx == LAST) ? S_DONE
                                        : S_READ;
      S_DONE:  state_nx = S_IDLE;
    endcase
  end

  // Start edge, mode latch, pair index, overflow count.
  always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
    if (!RESETN_I) begin
      start_q <= 1'b0;
      mode    <= MODE_SUMDIFF;
      idx     <= '0;
      ovf_cnt <= '0;
    end else begin
      start_q <= START_I;
      if (go) begin
        mode    <= mode_e'(MODE_I);
        idx     <= '0;
        ovf_cnt <= '0;
      end else if (state == S_WRITE) begin
        if (alu_bus.ovf) ovf_cnt <= ovf_cnt + 1'b1;
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
  end

  // Outputs are zero outside the active states.
  always_comb begin
    ADDR0_O  = '0;
    ADDR1_O  = '0;
    WDATA0_O = '0;
    WDATA1_O = '0;
    WE0_O    = 1'b0;
    WE1_O    = 1'b0;
    BUSY_O   = 1'b0;
    DONE_O   = 1'b0;
    unique case (state)
      S_IDLE: ;
      S_READ: begin
        ADDR0_O = idx;
        ADDR1_O = TOP - idx;
        BUSY_O  = 1'b1;
      end
      S_WRITE: begin
        ADDR0_O  = idx;
        ADDR1_O  = TOP - idx;
        WDATA0_O = alu_bus.w0;
        WDATA1_O = alu_bus.w1;
        WE0_O    = 1'b1;
        WE1_O    = 1'b1;
        BUSY_O   = 1'b1;
      end
      S_DONE: DONE_O = 1'b1;
    endcase
  end

  assign OVF_CNT_O = ovf_cnt;

endmodule

// File: tb/tb_mem_sweep.sv
// Scoreboard bench for mem_sweep with a
// 1-cycle-latency dual-port RAM model.
module tb_mem_sweep;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int HALF  = 256;

`ifdef MEM_SWEEP_SAT_EN
  localparam int SD_A511  = 0;
  localparam int SAT_A0   = 255;
`else
  localparam int SD_A511  = 1;
  localparam int SAT_A0   = 44;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'd0;
  logic [AW-1:0] addr0, addr1, ovf_cnt;
  logic [DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic          we0, we1, busy, done;

  always #10 clk = ~clk;

  mem_sweep #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLOCK_50_I(clk),
    .RESETN_I  (rst_n),
    .START_I   (start),
    .MODE_I    (mode),
    .ADDR0_O   (addr0),
    .ADDR1_O   (addr1),
    .WDATA0_O  (wdata0),
    .WDATA1_O  (wdata1),
    .WE0_O     (we0),
    .WE1_O     (we1),
    .RDATA0_I  (rdata0),
    .RDATA1_I  (rdata1),
    .BUSY_O    (busy),
    .DONE_O    (done),
    .OVF_CNT_O (ovf_cnt)
  );

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] stage   [DEPTH];
  logic [DW-1:0] cur_img [DEPTH];
  logic [DW-1:0] exp_img [DEPTH];
  logic [DW-1:0] orig    [DEPTH];
  logic          load = 1'b0;

  always @(posedge clk) begin
    if (load) begin
      ram <= stage;
    end else begin
      if (we0) ram[addr0] <= wdata0;
      if (we1) ram[addr1] <= wdata1;
    end
    rdata0 <= ram[addr0];
    rdata1 <= ram[addr1];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d",
               name, act, req);
    end
  endtask

  typedef struct {
    string       name;
    int unsigned start_cyc;
    int          ovf;
    int          a0;
    int          a511;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   mism;
  logic done_prev = 1'b0;

  // Monitor: every DONE pulse retires one expected sweep.
  always @(negedge clk) begin
    done_prev <= done;
    if (done) begin
      check("done_pulse_width", int'(done_prev), 0);
      check("busy_at_done", int'(busy), 0);
      done_cnt++;
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check({e.name, "_cycles"},
              int'(cyc - e.start_cyc), DEPTH);
        check({e.name, "_ovf"}, int'(ovf_cnt), e.ovf);
        if (e.a0 >= 0)
          check({e.name, "_ram0"}, int'(ram[0]), e.a0);
        if (e.a511 >= 0)
          check({e.name, "_ram511"},
                int'(ram[DEPTH-1]), e.a511);
        mism = 0;
        for (int k = 0; k < DEPTH; k++)
          if (ram[k] !== exp_img[k]) mism++;
        check({e.name, "_image"}, mism, 0);
      end
    end
  end

  // Reference sweep over cur_img into exp_img.
  function automatic int model(int m);
    int a, b, s, w0, w1, ov;
    ov = 0;
    for (int i = 0; i < HALF; i++) begin
      a = int'(cur_img[i]);
      b = int'(cur_img[DEPTH-1-i]);
      w0 = a;
      w1 = b;
      if (m == 0) begin
        s = a + b;
        if (s > 255 || a < b) ov++;
`ifdef MEM_SWEEP_SAT_EN
        w0 = (s > 255) ? 255 : s;
        w1 = (a < b) ? 0 : a - b;
`else
        w0 = s & 255;
        w1 = (a - b) & 255;
`endif
      end else if (m == 1) begin
        w0 = (a > b) ? a : b;
        w1 = (a > b) ? b : a;
      end else if (m == 2) begin
        w0 = b;
        w1 = a;
      end
      exp_img[i]       = DW'(w0);
      exp_img[DEPTH-1-i] = DW'(w1);
    end
    return ov;
  endfunction

  task automatic load_img();
    stage = cur_img;
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  task automatic issue(int m, string name,
                       int a0, int a511, bit push);
    exp_t x;
    int   ov;
    @(negedge clk);
    ov = model(m);
    if (push) begin
      x.name      = name;
      x.start_cyc = cyc + 1;
      x.ovf       = ov;
      x.a0        = a0;
      x.a511      = a511;
      q.push_back(x);
    end
    mode  = 2'(m);
    start = 1'b1;
  endtask

  task automatic wait_done(string name);
    int n;
    n = 0;
    while ((busy || q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      check({name, "_timeout"}, 1, 0);
      q.delete();
    end
    @(negedge clk);
    cur_img = exp_img;
  endtask

  task automatic check_zero(string tag);
    check({tag, "_addr0"},  int'(addr0), 0);
    check({tag, "_addr1"},  int'(addr1), 0);
    check({tag, "_wdata"},  int'({wdata0, wdata1}), 0);
    check({tag, "_we"},     int'({we0, we1}), 0);
    check({tag, "_busy"},   int'(busy), 0);
    check({tag, "_done"},   int'(done), 0);
    check({tag, "_ovfcnt"}, int'(ovf_cnt), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  int busy_cyc;
  int dc0;
  int n;

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Mode 0, RAM[k]=k: 128 pairs have a<b.
    for (int k = 0; k < DEPTH; k++) cur_img[k] = DW'(k);
    load_img();
    issue(0, "sumdiff", 255, SD_A511, 1'b1);
    wait_done("sumdiff");
    start = 1'b0;
    check("sumdiff_ovf_hand", int'(ovf_cnt), 128);

    // Mode 0, one carry pair (200,100), rest zero.
    for (int k = 0; k < DEPTH; k++) cur_img[k] = '0;
    cur_img[0]       = 8'd200;
    cur_img[DEPTH-1] = 8'd100;
    load_img();
    issue(0, "sat", SAT_A0, 100, 1'b1);
    wait_done("sat");
    start = 1'b0;
    check("sat_ovf_hand", int'(ovf_cnt), 1);
    repeat (20) @(negedge clk);
    check("ovf_hold", int'(ovf_cnt), 1);

    // Mode 1 max/min.
    for (int k = 0; k < DEPTH; k++)
      cur_img[k] = DW'(k ^ 8'h5a);
    cur_img[0]       = 8'd3;
    cur_img[DEPTH-1] = 8'd9;
    load_img();
    issue(1, "maxmin", 9, 3, 1'b1);
    wait_done("maxmin");
    start = 1'b0;
    check("maxmin_ovf", int'(ovf_cnt), 0);

    // Mode 2 twice, with an ignored edge mid-sweep.
    for (int k = 0; k < DEPTH; k++)
      cur_img[k] = DW'(k * 7 + 3);
    orig = cur_img;
    load_img();
    dc0 = done_cnt;
    issue(2, "swap1", 252, 3, 1'b1);
    repeat (50) @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    start = 1'b1;
    wait_done("swap1");
    busy_cyc = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
    end
    check("swap_held_start_busy", busy_cyc, 0);
    check("swap_sweep_count", done_cnt - dc0, 1);
    start = 1'b0;
    issue(2, "swap2", 3, 252, 1'b1);
    wait_done("swap2");
    start = 1'b0;
    mism = 0;
    for (int k = 0; k < DEPTH; k++)
      if (ram[k] !== orig[k]) mism++;
    check("swap_restored", mism, 0);

    // Mode 3 with reset at pair 100.
    for (int k = 0; k < DEPTH; k++)
      cur_img[k] = DW'(k * 3);
    load_img();
    dc0 = done_cnt;
    issue(3, "abort", -1, -1, 1'b0);
    n = 0;
    while (!(we0 && addr0 == 9'd100) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_pair100", int'(n < 1000), 1);
    #1 rst_n = 1'b0;
    #1 check_zero("abort");
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check("abort_no_done", done_cnt - dc0, 0);
    mism = 0;
    for (int k = 0; k < DEPTH; k++)
      if (ram[k] !== cur_img[k]) mism++;
    check("abort_ram_kept", mism, 0);
    issue(3, "pass", 0, 253, 1'b1);
    wait_done("pass");
    start = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
